// File: rtl/fpu_operand_sequencer.sv
// Initiator side of the FPU stb/ack handshake: queues operand pairs, strobes
// them into the arithmetic unit, then acknowledges and captures the result.
module fpu_operand_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WIDTH-1:0]         cmd_a_i,
  input  logic [WIDTH-1:0]         cmd_b_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [WIDTH-1:0]         fpu_a_o,
  output logic [WIDTH-1:0]         fpu_b_o,
  output logic                     fpu_a_stb_o,
  output logic                     fpu_b_stb_o,
  input  logic                     fpu_a_ack_i,
  input  logic                     fpu_b_ack_i,
  input  logic [WIDTH-1:0]         fpu_z_i,
  input  logic                     fpu_z_stb_i,
  output logic                     fpu_z_ack_o,
  output logic [WIDTH-1:0]         res_z_o,
  output logic                     res_valid_o,
  output logic                     res_timeout_o,
  output logic                     busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, ACK_Z} state_t;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  state_t           state_q;
  logic [TW-1:0]    tmo_q;
  logic [WIDTH-1:0] fpu_a_q, fpu_b_q, res_z_q;
  logic             a_stb_q, b_stb_q, z_ack_q, res_valid_q, res_timeout_q, busy_q;

  logic push, pop, tmo_hit, a_left, b_left;

  assign cmd_ready_o = (count_q != (AW+1)'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == IDLE) && (count_q != '0);
  assign tmo_hit     = (tmo_q == TW'(TIMEOUT - 1));
  // Strobes still outstanding after this edge's acks are applied.
  assign a_left      = a_stb_q && !fpu_a_ack_i;
  assign b_left      = b_stb_q && !fpu_b_ack_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wr_ptr_q] <= cmd_a_i;
      mem_b[wr_ptr_q] <= cmd_b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      tmo_q         <= '0;
      fpu_a_q       <= '0;
      fpu_b_q       <= '0;
      res_z_q       <= '0;
      a_stb_q       <= 1'b0;
      b_stb_q       <= 1'b0;
      z_ack_q       <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            fpu_a_q <= mem_a[rd_ptr_q];
            fpu_b_q <= mem_b[rd_ptr_q];
            a_stb_q <= 1'b1;
            b_stb_q <= 1'b1;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND, WAIT_Z: begin
          // Timeout takes priority over any handshake landing on the same edge.
          if (tmo_hit) begin
            a_stb_q       <= 1'b0;
            b_stb_q       <= 1'b0;
            res_z_q       <= QNAN;
            res_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
            if (state_q == SEND) begin
              if (fpu_a_ack_i) a_stb_q <= 1'b0;
              if (fpu_b_ack_i) b_stb_q <= 1'b0;
              if (!a_left && !b_left) state_q <= WAIT_Z;
            end else if (fpu_z_stb_i) begin
              res_z_q     <= fpu_z_i;
              z_ack_q     <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= ACK_Z;
            end
          end
        end
        ACK_Z: begin
          z_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_count_o  = count_q;
  assign fpu_a_o       = fpu_a_q;
  assign fpu_b_o       = fpu_b_q;
  assign fpu_a_stb_o   = a_stb_q;
  assign fpu_b_stb_o   = b_stb_q;
  assign fpu_z_ack_o   = z_ack_q;
  assign res_z_o       = res_z_q;
  assign res_valid_o   = res_valid_q;
  assign res_timeout_o = res_timeout_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Directed bench for fpu_operand_sequencer; the bench plays the FPU responder
// and checks handshake timing, ordering, backpressure, timeout and reset.
module tb_fpu_operand_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd_a, cmd_b, fpu_a, fpu_b, fpu_z, res_z;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  fifo_count;
  logic        fpu_a_stb, fpu_b_stb, fpu_a_ack, fpu_b_ack, fpu_z_stb, fpu_z_ack;
  logic        res_valid, res_timeout, busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fpu_operand_sequencer #(.WIDTH(32), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready), .fifo_count_o(fifo_count),
    .fpu_a_o(fpu_a), .fpu_b_o(fpu_b),
    .fpu_a_stb_o(fpu_a_stb), .fpu_b_stb_o(fpu_b_stb),
    .fpu_a_ack_i(fpu_a_ack), .fpu_b_ack_i(fpu_b_ack),
    .fpu_z_i(fpu_z), .fpu_z_stb_i(fpu_z_stb), .fpu_z_ack_o(fpu_z_ack),
    .res_z_o(res_z), .res_valid_o(res_valid), .res_timeout_o(res_timeout),
    .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] b);
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // One full transaction as the FPU: ack A at cycle da, B at cycle db, return z
  // dz cycles after the last ack. All sampling on negedges.
  task automatic do_txn(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] z,
                        input int da, input int db, input int dz);
    int w;
    w = 0;
    while (!(fpu_a_stb && fpu_b_stb) && w < 50) begin @(negedge clk); w++; end
    chk("launch", {31'b0, fpu_a_stb && fpu_b_stb}, 32'd1);
    chk("op_a", fpu_a, ea);
    chk("op_b", fpu_b, eb);
    chk("busy", {31'b0, busy}, 32'd1);
    for (int k = 0; k <= ((da > db) ? da : db); k++) begin
      fpu_a_ack = (k == da);
      fpu_b_ack = (k == db);
      @(negedge clk);
      chk("a_stb", {31'b0, fpu_a_stb}, {31'b0, k < da});
      chk("b_stb", {31'b0, fpu_b_stb}, {31'b0, k < db});
      chk("a_hold", fpu_a, ea);
    end
    fpu_a_ack = 1'b0; fpu_b_ack = 1'b0;
    repeat (dz) begin
      @(negedge clk);
      chk("zack_early", {31'b0, fpu_z_ack}, 32'd0);
    end
    fpu_z = z; fpu_z_stb = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!fpu_z_ack && w < 20);
    chk("zack", {31'b0, fpu_z_ack}, 32'd1);
    chk("res_valid", {31'b0, res_valid}, 32'd1);
    chk("res_z", res_z, z);
    fpu_z_stb = 1'b0;
    @(negedge clk);
    chk("zack_1cyc", {31'b0, fpu_z_ack}, 32'd0);
    chk("valid_1cyc", {31'b0, res_valid}, 32'd0);
  endtask

  initial begin
    logic bad;
    rst_n = 1'b0; cmd_a = '0; cmd_b = '0; cmd_valid = 1'b0;
    fpu_a_ack = 1'b0; fpu_b_ack = 1'b0; fpu_z = '0; fpu_z_stb = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_count", {29'b0, fifo_count}, 32'd0);
    chk("rst_stb", {30'b0, fpu_a_stb, fpu_b_stb}, 32'd0);
    chk("rst_out", fpu_a | fpu_b | res_z, 32'd0);
    chk("rst_flags", {28'b0, fpu_z_ack, res_valid, res_timeout, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Same-cycle acks, 5-cycle result latency, launch latency.
    push1(32'h417C0000, 32'h40E80000);
    chk("lat_n", {31'b0, fpu_a_stb}, 32'd0);
    @(negedge clk);
    chk("lat_n1", {31'b0, fpu_a_stb}, 32'd1);
    do_txn(32'h417C0000, 32'h40E80000, 32'h41080000, 0, 0, 5);

    // B acked three cycles before A.
    push1(32'h00000000, 32'h40E80000);
    do_txn(32'h00000000, 32'h40E80000, 32'hC0E80000, 3, 0, 2);

    // Stalled responder: one pops, four fill the FIFO, the sixth is rejected.
    for (int i = 0; i < 6; i++) begin
      cmd_a = 32'h3F800000 + i; cmd_b = 32'h40000000 + i; cmd_valid = 1'b1;
      if (i == 5) begin
        chk("full_ready", {31'b0, cmd_ready}, 32'd0);
        chk("full_count", {29'b0, fifo_count}, 32'd4);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("full_hold", {29'b0, fifo_count}, 32'd4);
    for (int i = 0; i < 5; i++)
      do_txn(32'h3F800000 + i, 32'h40000000 + i, 32'h42000000 + i, 0, 0, 1);
    chk("drained", {29'b0, fifo_count}, 32'd0);

    // Timeout with no acks; stray z_stb during SEND is ignored.
    push1(32'h11111111, 32'h22222222);
    push1(32'h33333333, 32'h44444444);
    chk("tmo_launch", {31'b0, fpu_a_stb}, 32'd1);
    fpu_z = 32'hDEADBEEF; fpu_z_stb = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 3) fpu_z_stb = 1'b0;
      if (k < 16 && (res_timeout || !fpu_a_stb || !fpu_b_stb || fpu_z_ack)) bad = 1'b1;
    end
    chk("tmo_early", {31'b0, bad}, 32'd0);
    chk("tmo_pulse", {31'b0, res_timeout}, 32'd1);
    chk("tmo_stb", {30'b0, fpu_a_stb, fpu_b_stb}, 32'd0);
    chk("tmo_res", res_z, 32'h7FC00000);
    chk("tmo_novalid", {31'b0, res_valid}, 32'd0);
    @(negedge clk);
    chk("tmo_1cyc", {31'b0, res_timeout}, 32'd0);
    do_txn(32'h33333333, 32'h44444444, 32'h55555555, 1, 1, 0);

    // Asynchronous reset mid-SEND with two entries queued.
    push1(32'hA0000001, 32'hB0000001);
    push1(32'hA0000002, 32'hB0000002);
    push1(32'hA0000003, 32'hB0000003);
    chk("pre_rst_stb", {31'b0, fpu_a_stb}, 32'd1);
    chk("pre_rst_cnt", {29'b0, fifo_count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stb", {30'b0, fpu_a_stb, fpu_b_stb}, 32'd0);
    chk("arst_cnt", {29'b0, fifo_count}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (fpu_a_stb || fpu_b_stb || busy) bad = 1'b1;
    end
    chk("post_rst_quiet", {31'b0, bad}, 32'd0);
    push1(32'h3F800000, 32'h3F800000);
    do_txn(32'h3F800000, 32'h3F800000, 32'h40000000, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
